// File: rtl/thermo_scan_scheduler.sv
// ============================================================================
//  Module  : thermo_scan_scheduler
//  Brief   : Round-robin scan of 4 thermocouple converters over one SPI master
//  Revision: 1.0
// ============================================================================
`default_nettype none

module thermo_scan_scheduler #(
    parameter int POWERUP = 1200,
    parameter int PERIOD  = 400,
    parameter int TIMEOUT = 64,
    parameter int CBITS   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ch_enable,
    input  logic        spi_not_busy,
    input  logic [31:0] spi_rx_data,
    output logic        spi_ena,
    output logic [1:0]  cs_sel,
    output logic        data_valid,
    output logic [1:0]  ch_id,
    output logic [13:0] tc_temp_data,
    output logic [11:0] junction_temp_data,
    output logic [3:0]  fault_bits,
    output logic [3:0]  fault_flags,
    output logic        timeout_err
);

    localparam logic [2:0] c_ST_WAIT_PWR = 3'd0;
    localparam logic [2:0] c_ST_SELECT   = 3'd1;
    localparam logic [2:0] c_ST_START    = 3'd2;
    localparam logic [2:0] c_ST_XFER     = 3'd3;
    localparam logic [2:0] c_ST_CAPTURE  = 3'd4;
    localparam logic [2:0] c_ST_IDLE     = 3'd5;

    localparam logic [CBITS-1:0] c_PWR_LAST = CBITS'(POWERUP - 1);
    localparam logic [CBITS-1:0] c_PER_LAST = CBITS'(PERIOD - 1);
    localparam logic [CBITS-1:0] c_TO_LAST  = CBITS'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CBITS-1:0] r_cnt;
    logic [1:0]       r_last;
    logic [1:0]       w_idx;
    logic [1:0]       w_pick;
    logic             w_found;
    logic [3:0]       w_fault_nibble;
    logic             w_unused;

    assign w_fault_nibble = {spi_rx_data[16], spi_rx_data[2:0]};
    assign w_unused       = ^{spi_rx_data[17], spi_rx_data[3]};

    // Search downward so the channel nearest after r_last wins; k=4 revisits r_last itself.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = '0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last + 2'(k);
            if (ch_enable[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_WAIT_PWR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_WAIT_PWR: if (r_cnt >= c_PWR_LAST) w_state_next = c_ST_SELECT;
            c_ST_SELECT:   w_state_next = w_found ? c_ST_START : c_ST_IDLE;
            c_ST_START: begin
                if (!spi_not_busy) begin
                    w_state_next = c_ST_XFER;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_XFER:     if (spi_not_busy) w_state_next = c_ST_CAPTURE;
            c_ST_CAPTURE:  w_state_next = c_ST_IDLE;
            c_ST_IDLE:     if (r_cnt >= c_PER_LAST) w_state_next = c_ST_SELECT;
            default:       w_state_next = c_ST_IDLE;
        endcase
    end

    // Decoded from state so an asynchronous reset drops the request immediately.
    always_comb begin
        spi_ena = 1'b0;
        if (r_state == c_ST_START) spi_ena = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt              <= '0;
            r_last             <= 2'd3;
            cs_sel             <= '0;
            data_valid         <= 1'b0;
            ch_id              <= '0;
            tc_temp_data       <= '0;
            junction_temp_data <= '0;
            fault_bits         <= '0;
            fault_flags        <= '0;
            timeout_err        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                c_ST_SELECT: begin
                    if (w_found) cs_sel <= w_pick;
                end
                c_ST_START: begin
                    if (spi_not_busy && (r_cnt == c_TO_LAST)) begin
                        timeout_err <= 1'b1;
                        r_last      <= cs_sel;
                    end
                end
                c_ST_CAPTURE: begin
                    tc_temp_data        <= spi_rx_data[31:18];
                    junction_temp_data  <= spi_rx_data[15:4];
                    fault_bits          <= w_fault_nibble;
                    ch_id               <= cs_sel;
                    fault_flags[cs_sel] <= |w_fault_nibble;
                    data_valid          <= 1'b1;
                    r_last              <= cs_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_thermo_scan_scheduler.sv
// ============================================================================
//  Module  : tb_thermo_scan_scheduler
//  Brief   : Directed self-checking bench for thermo_scan_scheduler
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_thermo_scan_scheduler;

    localparam int POWERUP = 8;
    localparam int PERIOD  = 4;
    localparam int TIMEOUT = 5;
    localparam int CBITS   = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ch_enable = 4'b0000;
    logic        spi_not_busy = 1'b1;
    logic [31:0] spi_rx_data = 32'h0;
    logic        spi_ena;
    logic [1:0]  cs_sel;
    logic        data_valid;
    logic [1:0]  ch_id;
    logic [13:0] tc_temp_data;
    logic [11:0] junction_temp_data;
    logic [3:0]  fault_bits;
    logic [3:0]  fault_flags;
    logic        timeout_err;

    bit spi_hang = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    thermo_scan_scheduler #(
        .POWERUP(POWERUP),
        .PERIOD (PERIOD),
        .TIMEOUT(TIMEOUT),
        .CBITS  (CBITS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ch_enable         (ch_enable),
        .spi_not_busy      (spi_not_busy),
        .spi_rx_data       (spi_rx_data),
        .spi_ena           (spi_ena),
        .cs_sel            (cs_sel),
        .data_valid        (data_valid),
        .ch_id             (ch_id),
        .tc_temp_data      (tc_temp_data),
        .junction_temp_data(junction_temp_data),
        .fault_bits        (fault_bits),
        .fault_flags       (fault_flags),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    // Channel 2 carries bit 16 set, so its fault nibble is 4'b1010; channel 3 faults via bit 16 only.
    function automatic logic [31:0] frame_of(input logic [1:0] c);
        case (c)
            2'd0:    return 32'h0000_0000;
            2'd1:    return 32'h1234_5670;
            2'd2:    return 32'hA5C3_7F12;
            default: return 32'h0001_0008;
        endcase
    endfunction

    // SPI master model: busy one cycle after spi_ena, busy for 3 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst && spi_ena && spi_not_busy && !spi_hang) begin
                spi_rx_data  = frame_of(cs_sel);
                spi_not_busy = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                spi_not_busy = 1'b1;
            end
        end
    end

    task automatic wait_dv(output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (data_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst       = 1'b1;
        ch_enable = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({spi_ena, cs_sel, data_valid, ch_id, tc_temp_data, junction_temp_data,
             fault_bits, fault_flags, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ena=%b cs=%0d dv=%b id=%0d tc=%h jt=%h fb=%b ff=%b to=%b, want all 0",
                     spi_ena, cs_sel, data_valid, ch_id, tc_temp_data, junction_temp_data,
                     fault_bits, fault_flags, timeout_err);
        end
        rst = 1'b0;
        n   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (spi_ena) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n !== 9) begin
            n_bad++;
            $display("FAIL first_spi_ena_latency: got %0d cycles, want 9", n);
        end
    endtask

    task automatic test_round_robin;
        bit got;
        int exp_id [5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            wait_dv(got);
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL rr_capture_%0d: no data_valid within bound, want ch %0d", k, exp_id[k]);
            end else if (ch_id !== 2'(exp_id[k])) begin
                n_bad++;
                $display("FAIL rr_capture_%0d: got ch %0d, want ch %0d", k, ch_id, exp_id[k]);
            end
            if (k == 2) begin
                n_cmp++;
                if (tc_temp_data !== 14'h2970) begin
                    n_bad++;
                    $display("FAIL ch2_tc_temp: got %h, want 2970", tc_temp_data);
                end
                n_cmp++;
                if (junction_temp_data !== 12'h7F1) begin
                    n_bad++;
                    $display("FAIL ch2_junction: got %h, want 7f1", junction_temp_data);
                end
                n_cmp++;
                if (fault_bits !== 4'b1010) begin
                    n_bad++;
                    $display("FAIL ch2_fault_bits: got %b, want 1010", fault_bits);
                end
                n_cmp++;
                if (fault_flags !== 4'b0100) begin
                    n_bad++;
                    $display("FAIL ch2_fault_flags: got %b, want 0100", fault_flags);
                end
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (data_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rr_dv_width_%0d: data_valid still %b one cycle later, want 0", k, data_valid);
            end
        end
        n_cmp++;
        if (fault_flags !== 4'b1100) begin
            n_bad++;
            $display("FAIL rr_fault_flags: got %b, want 1100", fault_flags);
        end
    endtask

    task automatic test_sparse;
        bit got;
        int exp_id [4] = '{1, 3, 1, 3};
        ch_enable = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_dv(got);
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL sparse_capture_%0d: no data_valid within bound, want ch %0d", k, exp_id[k]);
            end else if (ch_id !== 2'(exp_id[k])) begin
                n_bad++;
                $display("FAIL sparse_capture_%0d: got ch %0d, want ch %0d", k, ch_id, exp_id[k]);
            end
            if (k == 0) begin
                n_cmp++;
                if ({tc_temp_data, junction_temp_data, fault_bits} !== {14'h048D, 12'h567, 4'b0000}) begin
                    n_bad++;
                    $display("FAIL ch1_fields: got tc=%h jt=%h fb=%b, want tc=048d jt=567 fb=0000",
                             tc_temp_data, junction_temp_data, fault_bits);
                end
            end
        end
        ch_enable = 4'b0000;
    endtask

    task automatic test_disabled;
        int n_ena = 0;
        int n_dv  = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (spi_ena) n_ena++;
            if (data_valid) n_dv++;
        end
        n_cmp++;
        if (n_ena !== 0 || n_dv !== 0) begin
            n_bad++;
            $display("FAIL disabled_activity: got %0d spi_ena and %0d data_valid cycles, want 0 and 0", n_ena, n_dv);
        end
        n_cmp++;
        if (fault_flags !== 4'b1100) begin
            n_bad++;
            $display("FAIL disabled_fault_flags: got %b, want 1100", fault_flags);
        end
    endtask

    task automatic test_timeout;
        bit seen;
        int n_hi;
        int n_tmo;
        spi_hang  = 1'b1;
        ch_enable = 4'b1111;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (spi_ena) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen || cs_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL timeout_first_ch: seen=%b cs_sel=%0d, want seen=1 cs_sel=0", seen, cs_sel);
        end
        n_hi  = 1;
        n_tmo = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (timeout_err) n_tmo++;
            if (!spi_ena) break;
            n_hi++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (timeout_err) n_tmo++;
        end
        n_cmp++;
        if (n_hi !== 5) begin
            n_bad++;
            $display("FAIL timeout_ena_width: got %0d cycles, want 5", n_hi);
        end
        n_cmp++;
        if (n_tmo !== 1) begin
            n_bad++;
            $display("FAIL timeout_err_pulses: got %0d, want 1", n_tmo);
        end
        n_cmp++;
        if (fault_flags !== 4'b1100) begin
            n_bad++;
            $display("FAIL timeout_fault_flags: got %b, want 1100", fault_flags);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (spi_ena) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen || cs_sel !== 2'd1) begin
            n_bad++;
            $display("FAIL timeout_next_ch: seen=%b cs_sel=%0d, want seen=1 cs_sel=1", seen, cs_sel);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!spi_ena) break;
        end
        spi_hang = 1'b0;
    endtask

    task automatic test_reset_mid_xfer;
        bit busy;
        int n;
        busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!spi_not_busy) begin
                busy = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!busy) begin
            n_bad++;
            $display("FAIL xfer_reached: SPI never went busy within bound, want busy");
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({spi_ena, cs_sel, data_valid, ch_id, tc_temp_data, junction_temp_data,
             fault_bits, fault_flags, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got ena=%b cs=%0d dv=%b id=%0d tc=%h jt=%h fb=%b ff=%b to=%b, want all 0",
                     spi_ena, cs_sel, data_valid, ch_id, tc_temp_data, junction_temp_data,
                     fault_bits, fault_flags, timeout_err);
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (spi_ena) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n !== 9) begin
            n_bad++;
            $display("FAIL restart_spi_ena_latency: got %0d cycles, want 9", n);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse();
        test_disabled();
        test_timeout();
        test_reset_mid_xfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
